// File: rtl/deserializer.sv
// Deserializer: packs LANES-bit beats into WIDTH-bit words behind a one-deep output register.
// Defining DESERIALIZER_RX_PARITY_EN appends an even-parity beat to every word.
module deserializer #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [LANES-1:0]                 i_data,
  input  logic                             i_valid,
  input  logic                             i_clear,
  output logic [WIDTH-1:0]                 o_data,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic                             o_overrun,
  output logic [$clog2(WIDTH/LANES+1)-1:0] o_count,
  output logic                             o_parity_err
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);
`ifdef DESERIALIZER_RX_PARITY_EN
  localparam int LAST  = BEATS;
`else
  localparam int LAST  = BEATS - 1;
`endif

  logic [WIDTH-1:0] sr_q, sr_d, shifted, word;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept, final_beat, load;

  generate
    if (BEATS == 1) begin : g_shift_single
      assign shifted = i_data;
    end else if (MSB_FIRST) begin : g_shift_left
      assign shifted = {sr_q[WIDTH-LANES-1:0], i_data};
    end else begin : g_shift_right
      assign shifted = {i_data, sr_q[WIDTH-1:LANES]};
    end
  endgenerate

`ifdef DESERIALIZER_RX_PARITY_EN
  // The final beat carries parity only, so the word is already complete in sr_q.
  assign word = sr_q;
`else
  assign word = shifted;
`endif

  always_comb begin
    accept     = i_valid && !i_clear;
    final_beat = accept && (count_q == CW'(LAST));
    load       = final_beat && (!valid_q || o_ready);
    sr_d       = sr_q;
    count_d    = count_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    if (i_clear) begin
      sr_d      = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      count_d = final_beat ? '0 : count_q + 1'b1;
      if (count_q < CW'(BEATS)) begin
        sr_d = shifted;
      end
    end

    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (final_beat) begin
      overrun_d = 1'b1;
    end else if (valid_q && o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef DESERIALIZER_RX_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (load) begin
      perr_d = (i_data[0] != ^sr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_count   = count_q;
endmodule

// File: tb/tb_deserializer.sv
// Randomized bench for deserializer: two instances (1-lane LSB-first, 4-lane MSB-first)
// checked every cycle against a word-level model, plus pinned literal scenarios.
module tb_deserializer;
`ifdef DESERIALIZER_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, i_valid, i_clear, o_ready;
  logic        da;
  logic [3:0]  db;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_ovr, b_ovr, a_perr, b_perr;
  logic [5:0]  a_cnt;
  logic [3:0]  b_cnt;

  deserializer #(.WIDTH(32), .LANES(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_data(da), .i_valid(i_valid), .i_clear(i_clear),
    .o_data(a_data), .o_valid(a_valid), .o_ready(o_ready), .o_overrun(a_ovr),
    .o_count(a_cnt), .o_parity_err(a_perr)
  );

  deserializer #(.WIDTH(32), .LANES(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_data(db), .i_valid(i_valid), .i_clear(i_clear),
    .o_data(b_data), .o_valid(b_valid), .o_ready(o_ready), .o_overrun(b_ovr),
    .o_count(b_cnt), .o_parity_err(b_perr)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model state: beats collected so far and the output register contents.
  logic [3:0]  bq [2][0:32];
  int          bn [2];
  logic [31:0] m_data [2];
  logic        m_valid [2];
  logic        m_ovr [2];
  logic        m_perr [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bn[i] = 0; m_data[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_perr[i] = 1'b0;
    end
  endtask

  // Instance 0: 32 one-bit beats, first beat is bit 0. Instance 1: 8 nibbles, first is bits 31:28.
  task automatic model_update(input int i, input logic [3:0] d);
    int lanes, beats, pos;
    logic [31:0] w;
    logic hs, complete, perr;
    lanes = (i == 0) ? 1 : 4;
    beats = 32 / lanes;
    if (!reset_n) begin
      bn[i] = 0; m_data[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_perr[i] = 1'b0;
      return;
    end
    hs = m_valid[i] && o_ready;
    complete = 1'b0;
    perr = 1'b0;
    w = '0;
    if (i_clear) begin
      bn[i] = 0;
      m_ovr[i] = 1'b0;
    end else if (i_valid) begin
      bq[i][bn[i]] = (i == 0) ? (d & 4'h1) : d;
      bn[i]++;
      if (bn[i] == beats + PAR) begin
        complete = 1'b1;
        bn[i] = 0;
        for (int k = 0; k < beats; k++) begin
          pos = (i == 1) ? (beats - 1 - k) * lanes : k * lanes;
          w = w | (32'(bq[i][k]) << pos);
        end
        perr = (PAR == 1) && (bq[i][beats][0] != ^w);
      end
    end
    if (complete && (!m_valid[i] || o_ready)) begin
      m_data[i] = w; m_valid[i] = 1'b1; m_perr[i] = perr;
    end else if (complete) begin
      m_ovr[i] = 1'b1;
    end else if (hs) begin
      m_valid[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_data", a_data, m_data[0]);
      chk("a_valid", 32'(a_valid), 32'(m_valid[0]));
      chk("a_overrun", 32'(a_ovr), 32'(m_ovr[0]));
      chk("a_count", 32'(a_cnt), 32'(bn[0]));
      chk("a_parity_err", 32'(a_perr), 32'(m_perr[0]));
      chk("b_data", b_data, m_data[1]);
      chk("b_valid", 32'(b_valid), 32'(m_valid[1]));
      chk("b_overrun", 32'(b_ovr), 32'(m_ovr[1]));
      chk("b_count", 32'(b_cnt), 32'(bn[1]));
      chk("b_parity_err", 32'(b_perr), 32'(m_perr[1]));
    end
  end

  task automatic step(input logic v, input logic c, input logic r,
                      input logic [3:0] b_in, input logic a_in);
    i_valid = v; i_clear = c; o_ready = r; db = b_in; da = a_in;
    @(posedge clk);
    model_update(0, {3'b000, da});
    model_update(1, db);
    @(negedge clk);
  endtask

  task automatic send_a(input logic [31:0] w, input logic pbit, input logic r, input logic rlast);
    int nb;
    logic bit_v;
    nb = 32 + PAR;
    for (int k = 0; k < nb; k++) begin
      bit_v = (k < 32) ? w[k] : pbit;
      step(1'b1, 1'b0, (k == nb - 1) ? rlast : r, 4'($urandom), bit_v);
    end
  endtask

  task automatic send_b(input logic [31:0] w, input logic pbit, input logic r, input logic rlast);
    int nb;
    logic [3:0] nib;
    nb = 8 + PAR;
    for (int k = 0; k < nb; k++) begin
      nib = (k < 8) ? w[31 - 4*k -: 4] : {3'b000, pbit};
      step(1'b1, 1'b0, (k == nb - 1) ? rlast : r, nib, 1'($urandom));
    end
  endtask

  initial begin
    logic [31:0] w;
    reset_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; o_ready = 1'b0; da = 1'b0; db = '0;
    model_reset();
    #12;
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_a_count", 32'(a_cnt), 32'h0);
    chk("rst_b_overrun", 32'(b_ovr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Four-lane MSB-first word 0x12345678.
    send_b(32'h12345678, ^32'h12345678, 1'b1, 1'b1);
    chk("lit_b_data", b_data, 32'h12345678);
    chk("lit_b_valid", 32'(b_valid), 32'h1);
    chk("lit_b_count", 32'(b_cnt), 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);

    // Single-lane LSB-first word.
    send_a(32'hA5A5F00F, ^32'hA5A5F00F, 1'b1, 1'b1);
    chk("lit_a_data", a_data, 32'hA5A5F00F);
    chk("lit_a_valid", 32'(a_valid), 32'h1);
    chk("lit_a_count", 32'(a_cnt), 32'h0);

    // Overrun: word 1 held, word 2 dropped, clear drops the flag only.
    step(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    send_a(32'h1, 1'b1, 1'b0, 1'b0);
    chk("lit_ovr_first", a_data, 32'h1);
    send_a(32'h2, 1'b1, 1'b0, 1'b0);
    chk("lit_ovr_kept", a_data, 32'h1);
    chk("lit_ovr_set", 32'(a_ovr), 32'h1);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("lit_clr_ovr", 32'(a_ovr), 32'h0);
    chk("lit_clr_valid", 32'(a_valid), 32'h1);

    // Completion in the same cycle the held word is taken.
    send_a(32'h2, 1'b1, 1'b0, 1'b1);
    chk("lit_sim_data", a_data, 32'h2);
    chk("lit_sim_valid", 32'(a_valid), 32'h1);
    chk("lit_sim_ovr", 32'(a_ovr), 32'h0);

    // Asynchronous reset in the middle of a word.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 4'($urandom), 1'($urandom));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_a_data", a_data, 32'h0);
    chk("arst_a_valid", 32'(a_valid), 32'h0);
    chk("arst_a_count", 32'(a_cnt), 32'h0);
    chk("arst_b_count", 32'(b_cnt), 32'h0);
    chk("arst_b_data", b_data, 32'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    reset_n = 1'b1;
    w = $urandom;
    send_a(w, ^w, 1'b1, 1'b1);
    chk("lit_post_rst_data", a_data, w);
    chk("lit_post_rst_valid", 32'(a_valid), 32'h1);

`ifdef DESERIALIZER_RX_PARITY_EN
    step(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    send_a(32'h3, 1'b1, 1'b1, 1'b1);
    chk("lit_perr_bad", 32'(a_perr), 32'h1);
    send_a(32'h3, 1'b0, 1'b1, 1'b1);
    chk("lit_perr_good", 32'(a_perr), 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(9) < 7, $urandom_range(49) == 0, 1'($urandom_range(1)),
           4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the assembled word width in bits.
REQ-002 Parameter LANES, default 1, SHALL set the serial bits accepted per beat; WIDTH SHALL be an integer multiple of LANES.
REQ-003 Parameter MSB_FIRST, default 0, SHALL select bit ordering: 0 = first beat lands in the least significant bits, 1 = first beat lands in the most significant bits.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_data  input  LANES  SHALL carry the serial bits of the current beat.
REQ-007 i_valid  input  1  SHALL qualify i_data; a beat is accepted on every clk edge where i_valid=1 (no backpressure on input).
REQ-008 i_clear  input  1  SHALL synchronously discard the partial word, zero the beat counter and clear o_overrun.
REQ-009 o_data  output  WIDTH  SHALL hold the last completed word.
REQ-010 o_valid  output  1  SHALL indicate o_data holds an unconsumed word.
REQ-011 o_ready  input  1  SHALL indicate the consumer takes o_data this cycle when o_valid=1.
REQ-012 o_overrun  output  1  SHALL be a sticky flag for a dropped word.
REQ-013 o_count  output  clog2(BEATS+1)  SHALL expose the beats accepted in the current partial word.
REQ-014 o_parity_err  output  1  SHALL flag parity mismatch of o_data (see REQ-027).

Function
REQ-015 BEATS SHALL equal WIDTH/LANES; each word SHALL consume exactly BEATS accepted beats (BEATS+1 with RX_PARITY_EN).
REQ-016 Each accepted beat SHALL shift into an internal shift register: MSB_FIRST=0 shifts right inserting at the top LANES bits; MSB_FIRST=1 shifts left inserting at the bottom LANES bits.
REQ-017 o_count SHALL increment per accepted beat and wrap to 0 on the final beat of a word.
REQ-018 On the edge accepting the final beat, the complete word SHALL be copied to o_data and o_valid SHALL be 1 from the following cycle (latency 1 cycle after final beat).
REQ-019 o_valid SHALL hold, with o_data stable, until a cycle with o_valid=1 and o_ready=1, after which it SHALL clear unless REQ-020 applies.
REQ-020 Word completion in the same cycle as o_valid=1 and o_ready=1 SHALL load the new word, keep o_valid=1, and not set o_overrun.
REQ-021 Word completion while o_valid=1 and o_ready=0 SHALL drop the new word, keep old o_data, and set o_overrun=1.
REQ-022 o_overrun SHALL remain 1 until i_clear or reset.
REQ-023 i_clear SHALL take priority over a simultaneous i_valid beat (beat discarded) but SHALL NOT affect o_data/o_valid.
REQ-024 i_valid=0 cycles SHALL freeze the shift register and o_count.

Reset
REQ-025 reset_n=0 SHALL immediately force o_count=0, o_valid=0, o_overrun=0, o_parity_err=0, o_data=0, shift register=0, regardless of clk.
REQ-026 Reset asserted mid-word SHALL discard the partial word; the first beat after release SHALL be beat 0.

Configuration
REQ-027 With macro DESERIALIZER_RX_PARITY_EN defined, one extra beat SHALL follow each word; i_data[0] of that beat SHALL be the even-parity bit over the word, other lanes ignored; o_parity_err SHALL update with o_data and be 1 on mismatch.
REQ-028 Without DESERIALIZER_RX_PARITY_EN, no parity beat SHALL exist and o_parity_err SHALL be constant 0.

Verification
REQ-029 WIDTH=32, LANES=1, MSB_FIRST=0: 32 beats of 0xA5A5F00F LSB first -> o_valid=1 one cycle after beat 32, o_data=0xA5A5F00F.
REQ-030 WIDTH=32, LANES=4, MSB_FIRST=1: 8 nibbles 1,2,...,8 -> o_data=0x12345678, o_count back to 0.
REQ-031 Word 0x1 held with o_ready=0, second word 0x2 completes -> o_data stays 0x1, o_overrun=1; i_clear -> o_overrun=0.
REQ-032 Second word completes in the same cycle o_ready=1 -> o_data=0x2, o_valid stays 1, o_overrun=0.
REQ-033 reset_n pulsed low after 10 beats -> all outputs 0 at once; next 32 beats yield a correct word.
REQ-034 With DESERIALIZER_RX_PARITY_EN, word 0x00000003 plus parity bit 1 -> o_parity_err=1; parity bit 0 -> o_parity_err=0.
